matrix_gen_3x3_8bit: RTL and testbench

- Downstream consumer of the two-line 8-bit shift-RAM line buffer in the Canny front end.
- Takes the current-row pixel plus the two delayed-row taps and builds a column-aligned 3x3 pixel window.
- Re-times frame sync/href/clken to match the window.
- Zero-fills border rows and columns, and flags the cycles where the window is fully populated.
- Feeds the Gaussian/Sobel 3x3 kernels.

---
 rtl/matrix_gen_3x3_8bit_pkg.sv | 21 ++
 rtl/matrix_gen_3x3_8bit_sync_delay.sv | 40 ++++
 rtl/matrix_gen_3x3_8bit.sv | 186 ++++++++++++++++++
 tb/tb_matrix_gen_3x3_8bit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_gen_3x3_8bit_pkg.sv
// Shared video-pipeline constants and types for the 3x3 window generator
// and the kernel stages that follow it.
package matrix_gen_3x3_8bit_pkg;

  localparam int PIX_W       = 8;
  localparam int IMG_W       = 640;
  localparam int IMG_H       = 480;
  localparam int H_CNT_W_DEF = 11;
  localparam int V_CNT_W_DEF = 11;
  localparam int WIN_N       = 3;

  typedef logic [PIX_W-1:0] pix_t;

  // Frame timing bundle carried alongside the pixel data.
  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

endpackage

// File: rtl/matrix_gen_3x3_8bit_sync_delay.sv
// N-stage delay line for the frame timing bundle (vsync/href/clken).
// Every kernel stage re-times its sync signals with one of these.
module vip_sync_delay
  import matrix_gen_3x3_8bit_pkg::*;
#(
  parameter int N = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  sync_t sync_in,
  output sync_t sync_out
);

  sync_t pipe_d [N];
  sync_t pipe_q [N];

  // Next value of each stage: stage 0 takes the input, the rest shift.
  always_comb begin
    pipe_d[0] = sync_in;
    for (int i = 1; i < N; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Delay registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign sync_out = pipe_q[N-1];

endmodule

// File: rtl/matrix_gen_3x3_8bit.sv
// 3x3 pixel window generator sitting behind a two-line shift-RAM buffer.
// Stage 1 aligns the current-row pixel with the buffer taps (which arrive
// one cycle after the strobe); stage 2 shifts the aligned column into the
// window. Border taps are zero-filled and matrix_valid marks full windows.
//
// Strobe semantics: per_frame_clken is a one-cycle qualifier on per_img_y
// with no back-pressure; every cycle with clken high carries exactly one
// pixel, and matrix_frame_clken marks exactly one window update two cycles
// later. matrix_valid is only ever high together with matrix_frame_clken.
module matrix_gen_3x3_8bit
  import matrix_gen_3x3_8bit_pkg::*;
#(
  parameter int H_CNT_W   = H_CNT_W_DEF,
  parameter int V_CNT_W   = V_CNT_W_DEF,
  parameter int ZERO_FILL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_y,
  input  logic [PIX_W-1:0] row1_tap,
  input  logic [PIX_W-1:0] row2_tap,
  output logic             matrix_frame_vsync,
  output logic             matrix_frame_href,
  output logic             matrix_frame_clken,
  output logic             matrix_valid,
  output logic [PIX_W-1:0] matrix_p11,
  output logic [PIX_W-1:0] matrix_p12,
  output logic [PIX_W-1:0] matrix_p13,
  output logic [PIX_W-1:0] matrix_p21,
  output logic [PIX_W-1:0] matrix_p22,
  output logic [PIX_W-1:0] matrix_p23,
  output logic [PIX_W-1:0] matrix_p31,
  output logic [PIX_W-1:0] matrix_p32,
  output logic [PIX_W-1:0] matrix_p33
);

  localparam logic [H_CNT_W-1:0] COL_MAX = '1;
  localparam logic [V_CNT_W-1:0] ROW_MAX = '1;
  localparam logic               ZF      = (ZERO_FILL != 0);

  sync_t sync_in;
  sync_t sync_d1;
  sync_t sync_d2;

  logic [V_CNT_W-1:0] row_cnt_d, row_cnt_q;
  logic [H_CNT_W-1:0] col_cnt_d, col_cnt_q;
  logic [V_CNT_W-1:0] row_d1_d, row_d1_q;
  logic [H_CNT_W-1:0] col_d1_d, col_d1_q;
  pix_t               row3_d, row3_q;
  pix_t               row1_in, row2_in;
  pix_t               win_d [WIN_N][WIN_N];
  pix_t               win_q [WIN_N][WIN_N];
  logic               valid_d, valid_q;
  logic               vsync_rise, href_fall;

  assign sync_in = {per_frame_vsync, per_frame_href, per_frame_clken};

  // Stage-1 copy of the timing bundle; also the previous-cycle reference
  // for edge detection on vsync and href.
  vip_sync_delay #(.N(1)) u_sync_d1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_in  (sync_in),
    .sync_out (sync_d1)
  );

  // Second stage lines the timing up with the window registers.
  vip_sync_delay #(.N(1)) u_sync_d2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_in  (sync_d1),
    .sync_out (sync_d2)
  );

  // Row/column position of the pixel entering this cycle, saturating.
  always_comb begin
    vsync_rise = sync_in.vsync & ~sync_d1.vsync;
    href_fall  = ~sync_in.href & sync_d1.href;

    row_cnt_d = row_cnt_q;
    if (vsync_rise) begin
      row_cnt_d = '0;
    end else if (sync_in.vsync && href_fall && (row_cnt_q != ROW_MAX)) begin
      row_cnt_d = row_cnt_q + 1'b1;
    end

    col_cnt_d = col_cnt_q;
    if (!sync_in.href) begin
      col_cnt_d = '0;
    end else if (sync_in.clken && (col_cnt_q != COL_MAX)) begin
      col_cnt_d = col_cnt_q + 1'b1;
    end

    // A vsync rise clears the row of the pixel arriving in the same cycle.
    row_d1_d = vsync_rise ? '0 : row_cnt_q;
    col_d1_d = col_cnt_q;
    row3_d   = per_img_y;
  end

  // Position counters and stage-1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      row_d1_q  <= '0;
      col_d1_q  <= '0;
      row3_q    <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      row_d1_q  <= row_d1_d;
      col_d1_q  <= col_d1_d;
      row3_q    <= row3_d;
    end
  end

  // Hide line-buffer taps that do not yet hold rows of this frame.
  always_comb begin
    row1_in = row1_tap;
    row2_in = row2_tap;
    if (ZF && (row_d1_q < V_CNT_W'(1))) begin
      row1_in = '0;
    end
    if (ZF && (row_d1_q < V_CNT_W'(2))) begin
      row2_in = '0;
    end
  end

  // Window update: shift in a new column on each aligned strobe; between
  // lines the window is emptied so each line starts against zeros.
  always_comb begin
    win_d = win_q;
    if (sync_d1.clken) begin
      for (int i = 0; i < WIN_N; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = row2_in;
      win_d[1][2] = row1_in;
      win_d[2][2] = row3_q;
    end else if (ZF && !sync_d1.href) begin
      for (int i = 0; i < WIN_N; i++) begin
        for (int j = 0; j < WIN_N; j++) begin
          win_d[i][j] = '0;
        end
      end
    end

    valid_d = sync_d1.clken && (row_d1_q >= V_CNT_W'(2)) &&
              (col_d1_q >= H_CNT_W'(2));
  end

  // Window and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) begin
        for (int j = 0; j < WIN_N; j++) begin
          win_q[i][j] <= '0;
        end
      end
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  assign matrix_frame_vsync = sync_d2.vsync;
  assign matrix_frame_href  = sync_d2.href;
  assign matrix_frame_clken = sync_d2.clken;
  assign matrix_valid       = valid_q;

  assign matrix_p11 = win_q[0][0];
  assign matrix_p12 = win_q[0][1];
  assign matrix_p13 = win_q[0][2];
  assign matrix_p21 = win_q[1][0];
  assign matrix_p22 = win_q[1][1];
  assign matrix_p23 = win_q[1][2];
  assign matrix_p31 = win_q[2][0];
  assign matrix_p32 = win_q[2][1];
  assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_matrix_gen_3x3_8bit.sv
// Directed bench for matrix_gen_3x3_8bit: ramp frames (pixel = 16*row+col)
// with a behavioural line buffer, strobe gaps, mid-frame reset and a long
// line past the column counter range. A second instance runs without zero
// fill to observe raw taps on the first rows.
module tb_matrix_gen_3x3_8bit;

  localparam logic [7:0]  TAP_FILL  = 8'hAA;
  localparam logic [7:0]  TAP_JUNK  = 8'h5C;
  localparam logic [72:0] EXP_FIRST = {1'b1, 8'd0, 8'd1, 8'd2, 8'd16, 8'd17,
                                       8'd18, 8'd32, 8'd33, 8'd34};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href  = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] per_img_y = 8'h00;
  logic [7:0] row1_tap  = 8'h00;
  logic [7:0] row2_tap  = 8'h00;

  logic       m_vs, m_hr, m_ck, m_valid;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic       r_vs, r_hr, r_ck, r_valid;
  logic [7:0] r11, r12, r13, r21, r22, r23, r31, r32, r33;

  matrix_gen_3x3_8bit #(.H_CNT_W(11), .V_CNT_W(11), .ZERO_FILL(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .row1_tap(row1_tap), .row2_tap(row2_tap),
    .matrix_frame_vsync(m_vs), .matrix_frame_href(m_hr),
    .matrix_frame_clken(m_ck), .matrix_valid(m_valid),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33)
  );

  matrix_gen_3x3_8bit #(.H_CNT_W(11), .V_CNT_W(11), .ZERO_FILL(0)) u_raw (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .row1_tap(row1_tap), .row2_tap(row2_tap),
    .matrix_frame_vsync(r_vs), .matrix_frame_href(r_hr),
    .matrix_frame_clken(r_ck), .matrix_valid(r_valid),
    .matrix_p11(r11), .matrix_p12(r12), .matrix_p13(r13),
    .matrix_p21(r21), .matrix_p22(r22), .matrix_p23(r23),
    .matrix_p31(r31), .matrix_p32(r32), .matrix_p33(r33)
  );

  logic [72:0] cur_win, raw_win;
  assign cur_win = {m_valid, p11, p12, p13, p21, p22, p23, p31, p32, p33};
  assign raw_win = {r_valid, r11, r12, r13, r21, r22, r23, r31, r32, r33};

  // ---------------- scoreboard state ----------------
  logic [72:0] exp_q[$];
  logic [23:0] exp_rc_q[$];
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [72:0] prev_win = '0;
  logic        got_first = 1'b0;
  logic [72:0] first_win = '0;
  logic [23:0] first_rc = '0;
  logic [2:0]  sh1 = '0;
  logic [2:0]  sh2 = '0;
  logic        prev_stb = 1'b0;
  int          prev_r = 0;
  int          prev_c = 0;

  task automatic chk(input string tag, input logic [72:0] got,
                     input logic [72:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  // Reference window for the strobe carrying pixel (r,c): rows r-2..r,
  // columns c-2..c, zero outside the frame.
  function automatic logic [72:0] win_exp(input int r, input int c);
    logic [72:0] w;
    int k;
    w = '0;
    w[72] = (r >= 2) && (c >= 2);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        k = i * 3 + j;
        if ((r - 2 + i >= 0) && (c - 2 + j >= 0)) begin
          w[71 - 8*k -: 8] = pix(r - 2 + i, c - 2 + j);
        end
      end
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle of input; the line-buffer taps carry the previous strobe's
  // column from rows r-1 / r-2 (TAP_FILL where the buffer holds no row yet).
  task automatic drive(input logic v, input logic h, input logic c,
                       input logic [7:0] y, input int r, input int col);
    @(negedge clk);
    if (prev_stb) begin
      row1_tap = (prev_r >= 1) ? pix(prev_r - 1, prev_c) : TAP_FILL;
      row2_tap = (prev_r >= 2) ? pix(prev_r - 2, prev_c) : TAP_FILL;
    end else begin
      row1_tap = TAP_JUNK;
      row2_tap = TAP_JUNK;
    end
    per_frame_vsync = v;
    per_frame_href  = h;
    per_frame_clken = c;
    per_img_y       = y;
    prev_stb = c;
    prev_r   = r;
    prev_c   = col;
    if (c) begin
      exp_q.push_back(win_exp(r, col));
      exp_rc_q.push_back({12'(r), 12'(col)});
    end
  endtask

  task automatic run_frame(input int rows, input int cols, input int gap,
                           input int stop_at);
    int n;
    n = 0;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00, 0, 0);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        drive(1'b1, 1'b1, 1'b1, pix(r, c), r, c);
        n++;
        if (stop_at >= 0 && n == stop_at) return;
        repeat (gap) drive(1'b1, 1'b1, 1'b0, 8'h77, r, c);
      end
      repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00, r, 0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
  endtask

  // Input history used to check the two-cycle sync re-timing.
  always @(posedge clk) begin
    sh2 <= sh1;
    sh1 <= {per_frame_vsync, per_frame_href, per_frame_clken};
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [72:0] ew;
    logic [23:0] rc;
    if (mon_en) begin
      chk("sync_d2", 73'({m_vs, m_hr, m_ck}), 73'(sh2));
      chk("valid_wo_clken", 73'(m_valid & ~m_ck), 73'(0));
      if (m_ck) begin
        if (exp_q.size() == 0) begin
          chk("strobe_q_depth", 73'(exp_q.size()), 73'(1));
        end else begin
          ew = exp_q.pop_front();
          rc = exp_rc_q.pop_front();
          chk("window", cur_win, ew);
          if (rc[23:12] == 12'd0)
            chk("raw_row0_p13_p23", 73'({r13, r23}), 73'({TAP_FILL, TAP_FILL}));
          if (rc[23:12] == 12'd1)
            chk("raw_row1_p13_p23", 73'({r13, r23}),
                73'({TAP_FILL, pix(0, int'(rc[11:0]))}));
          if (m_valid && !got_first) begin
            got_first = 1'b1;
            first_win = cur_win;
            first_rc  = rc;
          end
        end
      end else if (m_hr) begin
        chk("hold", cur_win, {1'b0, prev_win[71:0]});
      end
    end
    prev_win = cur_win;
  end

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 73'(exp_q.size()), 73'(0));
  endtask

  task automatic check_first();
    chk("first_valid_seen", 73'(got_first), 73'(1));
    chk("first_valid_win", first_win, EXP_FIRST);
    chk("first_valid_rc", 73'(first_rc), 73'({12'd2, 12'd2}));
    got_first = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_win", cur_win, '0);
    chk("rst_sync", 73'({m_vs, m_hr, m_ck}), 73'(0));
    chk("rst_raw_win", raw_win, '0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    mon_en = 1'b1;

    // 4x4 ramp, continuous strobe
    run_frame(4, 4, 0, -1);
    drain();
    check_first();

    // 6-px lines with a strobe every third cycle
    run_frame(4, 6, 2, -1);
    drain();
    check_first();

    // Reset in the middle of the second line, href high
    mon_en = 1'b0;
    run_frame(3, 4, 0, 6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_win", cur_win, '0);
    chk("midrst_sync", 73'({m_vs, m_hr, m_ck}), 73'(0));
    chk("midrst_raw_win", raw_win, '0);
    exp_q.delete();
    exp_rc_q.delete();
    prev_stb = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    mon_en = 1'b1;
    run_frame(4, 4, 0, -1);
    drain();
    check_first();

    // Long lines beyond the column counter range
    run_frame(3, 2100, 0, -1);
    drain();
    check_first();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
